// File: rtl/sprite_pkg.sv
// sprite_pkg
//   Constants and types shared by the sprite frame memory write side
//   (sprite_rle_loader) and the VGA-side frame readers.
//   - DEPTH / ADDR_W : pixel entries per image and the address width that
//                      both writers and readers use.
//   - IDX_W / PALETTE_N : palette index width and number of legal entries.
//   - RUN_W, IDX_LSB, RUN_LSB : layout of one RLE byte
//                      ([RUN_LSB +: RUN_W] = run-1, [IDX_LSB +: IDX_W] = index).
//   - loader_state_t : loader FSM states.
package sprite_pkg;

  localparam int DEPTH     = 49152;   // 256 x 192
  localparam int ADDR_W    = 19;
  localparam int IDX_W     = 3;
  localparam int RUN_W     = 5;
  localparam int PALETTE_N = 6;

  localparam int IDX_LSB   = 0;
  localparam int RUN_LSB   = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EMIT  = 2'd2
  } loader_state_t;

endpackage

// File: rtl/sprite_rle_loader.sv
// sprite_rle_loader
//   Run-length decoder that fills the 3-bit palette-index sprite RAM from a
//   byte stream. Each byte carries an index and a run length (run+1 pixels);
//   the block turns it into consecutive write strobes starting at address 0.
//
// Ports
//   Clk           : system clock, rising edge
//   Reset_n       : synchronous active-low reset
//   start         : one-cycle pulse, begins a load at address 0 (IDLE only)
//   in_data       : RLE byte, [2:0] index, [7:3] run (length = run+1)
//   in_valid      : in_data valid
//   in_ready      : byte accepted when in_valid && in_ready
//   we            : write strobe to the sprite RAM
//   write_address : pixel address (meaningful when we=1)
//   write_data    : palette index (meaningful when we=1)
//   busy          : load in progress
//   done          : one-cycle pulse after the write to DEPTH-1
//   overrun       : sticky, the final run was truncated at DEPTH-1
//   bad_index     : sticky, an index >= PALETTE_N was received
module sprite_rle_loader
  import sprite_pkg::*;
#(
  parameter int P_DEPTH     = DEPTH,
  parameter int P_ADDR_W    = ADDR_W,
  parameter int P_IDX_W     = IDX_W,
  parameter int P_RUN_W     = RUN_W,
  parameter int P_PALETTE_N = PALETTE_N
) (
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic                start,
  input  logic [7:0]          in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic                we,
  output logic [P_ADDR_W-1:0] write_address,
  output logic [P_IDX_W-1:0]  write_data,
  output logic                busy,
  output logic                done,
  output logic                overrun,
  output logic                bad_index
);

  localparam logic [P_ADDR_W-1:0] LAST_ADDR = P_ADDR_W'(P_DEPTH - 1);

  loader_state_t       state_reg;
  // Address of the next pixel to be written.
  logic [P_ADDR_W-1:0] addr_reg;
  // Pixels still to write after the one currently on the write port.
  // This is exactly the run field of the byte, so no +1/-1 adjustment.
  logic [P_RUN_W-1:0]  count_reg;
  logic                we_reg;
  logic [P_ADDR_W-1:0] write_address_reg;
  logic [P_IDX_W-1:0]  write_data_reg;
  logic                busy_reg;
  logic                done_reg;
  logic                overrun_reg;
  logic                bad_index_reg;

  logic [P_IDX_W-1:0]  in_idx;
  logic [P_RUN_W-1:0]  in_run;
  logic                in_idx_bad;

  assign in_idx     = in_data[IDX_LSB +: P_IDX_W];
  assign in_run     = in_data[RUN_LSB +: P_RUN_W];
  assign in_idx_bad = (int'(in_idx) >= P_PALETTE_N);

  // The first pixel of a run is put on the write port in the same edge that
  // accepts the byte, so a byte accepted in cycle N writes in cycle N+1.
  // In EMIT the registered outputs describe the write happening this cycle;
  // the decision for the following cycle looks at that write's address and
  // the remaining count.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_reg         <= IDLE;
      addr_reg          <= '0;
      count_reg         <= '0;
      we_reg            <= 1'b0;
      write_address_reg <= '0;
      write_data_reg    <= '0;
      busy_reg          <= 1'b0;
      done_reg          <= 1'b0;
      overrun_reg       <= 1'b0;
      bad_index_reg     <= 1'b0;
    end else begin
      done_reg <= 1'b0;

      case (state_reg)
        IDLE: begin
          we_reg <= 1'b0;
          if (start) begin
            state_reg     <= FETCH;
            addr_reg      <= '0;
            overrun_reg   <= 1'b0;
            bad_index_reg <= 1'b0;
            busy_reg      <= 1'b1;
          end
        end

        FETCH: begin
          we_reg <= 1'b0;
          if (in_valid) begin
            // Illegal indices are flagged but still written unchanged.
            if (in_idx_bad) begin
              bad_index_reg <= 1'b1;
            end
            we_reg            <= 1'b1;
            write_address_reg <= addr_reg;
            write_data_reg    <= in_idx;
            addr_reg          <= addr_reg + P_ADDR_W'(1);
            count_reg         <= in_run;
            state_reg         <= EMIT;
          end
        end

        EMIT: begin
          if (write_address_reg == LAST_ADDR) begin
            // Image complete; any pixels left in the run are dropped.
            if (count_reg != '0) begin
              overrun_reg <= 1'b1;
            end
            we_reg    <= 1'b0;
            done_reg  <= 1'b1;
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end else if (count_reg == '0) begin
            we_reg    <= 1'b0;
            state_reg <= FETCH;
          end else begin
            // write_data_reg keeps the run's index.
            we_reg            <= 1'b1;
            write_address_reg <= addr_reg;
            addr_reg          <= addr_reg + P_ADDR_W'(1);
            count_reg         <= count_reg - P_RUN_W'(1);
          end
        end

        default: begin
          we_reg    <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign in_ready      = (state_reg == FETCH);
  assign we            = we_reg;
  assign write_address = write_address_reg;
  assign write_data    = write_data_reg;
  assign busy          = busy_reg;
  assign done          = done_reg;
  assign overrun       = overrun_reg;
  assign bad_index     = bad_index_reg;

endmodule

// File: tb/tb_sprite_rle_loader.sv
// tb_sprite_rle_loader
//   Self-checking bench for sprite_rle_loader. A reference model expands each
//   sent byte into the list of (address, index) writes it must produce and
//   tracks the expected overrun / bad_index flags; a monitor compares every
//   write strobe against that list.
module tb_sprite_rle_loader;
  import sprite_pkg::*;

  localparam int D = DEPTH;

  logic              Clk = 1'b0;
  logic              Reset_n = 1'b0;
  logic              start = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              we;
  logic [ADDR_W-1:0] write_address;
  logic [IDX_W-1:0]  write_data;
  logic              busy;
  logic              done;
  logic              overrun;
  logic              bad_index;

  always #5 Clk = ~Clk;

  sprite_rle_loader dut (
    .Clk           (Clk),
    .Reset_n       (Reset_n),
    .start         (start),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .we            (we),
    .write_address (write_address),
    .write_data    (write_data),
    .busy          (busy),
    .done          (done),
    .overrun       (overrun),
    .bad_index     (bad_index)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int exp_addr[$];
  int exp_data[$];
  int model_addr;
  bit model_over;
  bit model_bad;

  function automatic void model_reset();
    exp_addr.delete();
    exp_data.delete();
    model_addr = 0;
    model_over = 0;
    model_bad  = 0;
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    int idx;
    int len;
    idx = int'(b[2:0]);
    len = int'(b[7:3]) + 1;
    if (idx >= PALETTE_N) model_bad = 1;
    for (int k = 0; k < len; k++) begin
      if (model_addr < D) begin
        exp_addr.push_back(model_addr);
        exp_data.push_back(idx);
        model_addr++;
      end else begin
        model_over = 1;
      end
    end
  endfunction

  function automatic logic [7:0] mk_byte(input int idx, input int len);
    logic [4:0] r;
    logic [2:0] i;
    r = 5'(len - 1);
    i = 3'(idx);
    return {r, i};
  endfunction

  // ---------------- monitor ----------------
  bit mon_en = 0;
  int cyc = 0;
  int last_wr_cyc = -1;
  int done_cnt = 0;
  int mon_a;
  int mon_d;

  always @(posedge Clk) cyc <= cyc + 1;

  always @(negedge Clk) begin
    if (mon_en) begin
      if (we) begin
        check("in_ready_low_during_we", 32'(in_ready), 32'd0);
        if (exp_addr.size() == 0) begin
          check("unexpected_we", 32'(we), 32'd0);
        end else begin
          mon_a = exp_addr.pop_front();
          mon_d = exp_data.pop_front();
          check("wr_addr", 32'(write_address), 32'(mon_a));
          check("wr_data", 32'(write_data), 32'(mon_d));
        end
        if (int'(write_address) == D - 1) last_wr_cyc = cyc;
      end
      if (done) done_cnt++;
    end
  end

  // ---------------- driver helpers ----------------
  int gap_max = 0;
  int start_cyc = 0;

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"},  32'(in_ready), 32'd0);
    check({tag, "_we"},        32'(we), 32'd0);
    check({tag, "_waddr"},     32'(write_address), 32'd0);
    check({tag, "_wdata"},     32'(write_data), 32'd0);
    check({tag, "_busy"},      32'(busy), 32'd0);
    check({tag, "_done"},      32'(done), 32'd0);
    check({tag, "_overrun"},   32'(overrun), 32'd0);
    check({tag, "_bad_index"}, 32'(bad_index), 32'd0);
  endtask

  // Called at a negedge; pulses start and checks the FETCH/busy response.
  task automatic do_start();
    start = 1'b1;
    start_cyc = cyc;
    @(negedge Clk);
    start = 1'b0;
    model_reset();
    check("busy_after_start", 32'(busy), 32'd1);
    check("ready_after_start", 32'(in_ready), 32'd1);
  endtask

  // Called at a negedge; returns at the negedge of the first write cycle.
  task automatic send_byte(input logic [7:0] b);
    int guard;
    int gap;
    guard = 0;
    gap = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
    in_valid = 1'b0;
    repeat (gap) @(negedge Clk);
    model_byte(b);
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && guard < 100) begin
      @(negedge Clk);
      guard++;
    end
    check("accept_in_time", 32'(guard < 100), 32'd1);
    @(negedge Clk);
    in_valid = 1'b0;
    check("first_we_latency", 32'(we), 32'd1);
  endtask

  task automatic wait_drain(input string tag);
    int guard;
    guard = 0;
    while (exp_addr.size() != 0 && guard < 200) begin
      @(negedge Clk);
      guard++;
    end
    @(negedge Clk);
    check(tag, 32'(exp_addr.size()), 32'd0);
  endtask

  // ---------------- scenarios ----------------
  initial begin
    int guard;
    int n_bytes;
    int len;
    int idx;
    logic [7:0] b;
    bit acc;

    Reset_n = 1'b0;
    repeat (3) @(negedge Clk);
    check_all_zero("reset");
    Reset_n = 1'b1;
    model_reset();
    mon_en = 1;
    @(negedge Clk);

    // Directed: index 2 x2 then index 3 x1.
    gap_max = 2;
    do_start();
    send_byte(8'h0A);
    send_byte(8'h03);
    wait_drain("directed_drain");
    $display("scenario directed: 2 bytes sent, errors so far %0d", n_errors);

    // Random short runs with start pulses during EMIT (must be ignored).
    for (int i = 0; i < 8; i++) begin
      b = mk_byte(int'($urandom_range(0, 5)), int'($urandom_range(1, 8)));
      send_byte(b);
      start = 1'b1;
      @(negedge Clk);
      start = 1'b0;
    end
    wait_drain("start_ignored_drain");
    check("busy_mid_load", 32'(busy), 32'd1);
    $display("scenario start-in-emit: 8 bytes sent, errors so far %0d", n_errors);

    // Fill up to just below address 100, then a 32-run of illegal index 7.
    while (model_addr + 32 <= 100) begin
      send_byte(mk_byte(int'($urandom_range(0, 5)), int'($urandom_range(1, 32))));
    end
    send_byte(mk_byte(7, 32));
    guard = 0;
    while (!(we && int'(write_address) == 100) && guard < 200) begin
      @(negedge Clk);
      guard++;
    end
    check("reached_addr_100", 32'(write_address), 32'd100);
    check("bad_index_set", 32'(bad_index), 32'd1);
    check("data_index_7", 32'(write_data), 32'd7);
    Reset_n = 1'b0;
    @(negedge Clk);
    check_all_zero("midrun_reset");
    Reset_n = 1'b1;
    model_reset();
    $display("scenario mid-run reset at addr 100, errors so far %0d", n_errors);

    // in_valid held high in IDLE: never acknowledged, never written.
    acc = 0;
    in_data  = 8'hF9;
    in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge Clk);
      acc = acc | in_ready | we;
    end
    in_valid = 1'b0;
    check("idle_no_accept", 32'(acc), 32'd0);
    check("done_count_before_full", 32'(done_cnt), 32'd0);
    @(negedge Clk);
    $display("scenario idle in_valid: 16 cycles, errors so far %0d", n_errors);

    // Full image of random runs, ending with a 32-run starting at D-12.
    gap_max = 0;
    do_start();
    n_bytes = 0;
    while (model_addr < D - 12) begin
      len = int'($urandom_range(1, 32));
      if (len > D - 12 - model_addr) len = D - 12 - model_addr;
      idx = ($urandom_range(0, 199) == 0) ? int'($urandom_range(6, 7)) : int'($urandom_range(0, 5));
      send_byte(mk_byte(idx, len));
      n_bytes++;
    end
    send_byte(mk_byte(int'($urandom_range(0, 5)), 32));
    n_bytes++;
    guard = 0;
    while (!done && guard < 100) begin
      @(negedge Clk);
      guard++;
    end
    check("done_seen", 32'(done), 32'd1);
    check("load_cycles", 32'(cyc - start_cyc), 32'(D + n_bytes + 1));
    check("done_after_last_write", 32'(cyc - last_wr_cyc), 32'd1);
    check("busy_low_at_done", 32'(busy), 32'd0);
    check("overrun_at_done", 32'(overrun), 32'(model_over));
    check("bad_index_at_done", 32'(bad_index), 32'(model_bad));
    @(negedge Clk);
    check("done_one_cycle", 32'(done), 32'd0);
    check("overrun_sticky", 32'(overrun), 32'(model_over));
    check("bad_index_sticky", 32'(bad_index), 32'(model_bad));
    check("all_writes_seen", 32'(exp_addr.size()), 32'd0);
    check("done_count", 32'(done_cnt), 32'd1);
    repeat (4) @(negedge Clk);
    check("idle_after_done", 32'(in_ready), 32'd0);
    $display("scenario full image: %0d bytes, errors so far %0d", n_bytes, n_errors);

    // A new start clears the sticky flags.
    do_start();
    check("overrun_cleared", 32'(overrun), 32'd0);
    check("bad_index_cleared", 32'(bad_index), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
